// File: rtl/gmii_fcs_checker.sv
// GMII receive-side frame delineation and CRC-32 FCS checker with registered pass-through.
// Define GMII_FCS_CHECKER_STRIP_EN to forward through a 5-deep delay line that removes the FCS bytes.
module gmii_fcs_checker #(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int MIN_FRAME_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_d,
  input  logic        gmii_en,
  input  logic        gmii_er,
  output logic [7:0]  m_gmii_d,
  output logic        m_gmii_en,
  output logic        m_gmii_er,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic        frame_fcs_ok,
  output logic        frame_gmii_err,
  output logic        frame_no_sfd,
  output logic        frame_runt,
  output logic        frame_oversize,
  output logic [31:0] fcs_err_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] len_reg, len_next;
  logic        no_sfd_reg, no_sfd_next;
  logic        err_reg, err_next;
  logic        quiet_reg, quiet_next;
  logic        frame_end;
  logic        end_no_sfd;
  logic        end_fcs_ok;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_next  = state_reg;
    crc_next    = crc_reg;
    len_next    = len_reg;
    no_sfd_next = no_sfd_reg;
    err_next    = err_reg;
    frame_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gmii_en) begin
          crc_next    = CRC_INIT;
          len_next    = 16'h0;
          no_sfd_next = 1'b0;
          err_next    = gmii_er;
          if (quiet_reg) begin
            state_next  = DROP;
            no_sfd_next = 1'b1;
          end else if (gmii_d == 8'h55) begin
            state_next = PRE;
          end else if (gmii_d == 8'hD5) begin
            state_next = DATA;
          end else begin
            state_next  = DROP;
            no_sfd_next = 1'b1;
          end
        end
      end
      default: begin
        if (!gmii_en) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          err_next = err_reg | gmii_er;
          case (state_reg)
            PRE: begin
              if (gmii_d == 8'hD5) begin
                state_next = DATA;
              end else if (gmii_d != 8'h55) begin
                state_next  = DROP;
                no_sfd_next = 1'b1;
              end
            end
            DATA: begin
              crc_next = crc_byte(crc_reg, gmii_d);
              len_next = (len_reg == 16'hFFFF) ? len_reg : len_reg + 16'd1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // After reset the line may be mid-frame; stay silent until an idle cycle is seen.
  assign quiet_next = quiet_reg & gmii_en;

  assign end_no_sfd = no_sfd_reg | (state_reg == PRE);
  assign end_fcs_ok = (crc_reg == CRC_RESIDUE) && (len_reg >= 16'd4) && !end_no_sfd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      crc_reg        <= CRC_INIT;
      len_reg        <= 16'h0;
      no_sfd_reg     <= 1'b0;
      err_reg        <= 1'b0;
      quiet_reg      <= 1'b1;
      frame_valid    <= 1'b0;
      frame_len      <= 16'h0;
      frame_fcs_ok   <= 1'b0;
      frame_gmii_err <= 1'b0;
      frame_no_sfd   <= 1'b0;
      frame_runt     <= 1'b0;
      frame_oversize <= 1'b0;
      fcs_err_cnt    <= 32'h0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      len_reg     <= len_next;
      no_sfd_reg  <= no_sfd_next;
      err_reg     <= err_next;
      quiet_reg   <= quiet_next;
      frame_valid <= frame_end & !quiet_reg;
      if (frame_end && !quiet_reg) begin
        frame_len      <= len_reg;
        frame_fcs_ok   <= end_fcs_ok;
        frame_gmii_err <= err_reg;
        frame_no_sfd   <= end_no_sfd;
        frame_runt     <= {16'h0, len_reg} < MIN_FRAME_LEN;
        frame_oversize <= {16'h0, len_reg} > MAX_FRAME_LEN;
        if (!end_fcs_ok && fcs_err_cnt != 32'hFFFFFFFF) begin
          fcs_err_cnt <= fcs_err_cnt + 32'd1;
        end
      end
    end
  end

`ifdef GMII_FCS_CHECKER_STRIP_EN
  logic [3:0][7:0] d_pipe;
  logic [3:0]      en_pipe;
  logic [3:0]      er_pipe;
  logic [3:0]      dat_pipe;
  logic            cur_data;
  logic            strip;

  // A post-SFD byte is FCS (or part of a too-short frame) unless four more
  // post-SFD bytes follow it: three still in the line plus the one on the input.
  assign cur_data = (state_reg == DATA) && gmii_en;
  assign strip    = dat_pipe[3] && !(&{dat_pipe[2:0], cur_data});

  always_ff @(posedge clk) begin
    if (rst) begin
      d_pipe    <= '0;
      en_pipe   <= '0;
      er_pipe   <= '0;
      dat_pipe  <= '0;
      m_gmii_d  <= 8'h0;
      m_gmii_en <= 1'b0;
      m_gmii_er <= 1'b0;
    end else begin
      d_pipe[0]   <= gmii_d;
      en_pipe[0]  <= gmii_en;
      er_pipe[0]  <= gmii_er;
      dat_pipe[0] <= cur_data;
      for (int i = 1; i < 4; i++) begin
        d_pipe[i]   <= d_pipe[i-1];
        en_pipe[i]  <= en_pipe[i-1];
        er_pipe[i]  <= er_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      m_gmii_d  <= strip ? 8'h0 : d_pipe[3];
      m_gmii_en <= en_pipe[3] & !strip;
      m_gmii_er <= er_pipe[3] & !strip;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      m_gmii_d  <= 8'h0;
      m_gmii_en <= 1'b0;
      m_gmii_er <= 1'b0;
    end else begin
      m_gmii_d  <= gmii_d;
      m_gmii_en <= gmii_en;
      m_gmii_er <= gmii_er;
    end
  end
`endif

endmodule
